// File: rtl/gamma_lut_ctrl.sv
// Host-side controller for three gamma LUTs: queues host writes and commits them
// only during blanking, and serves host reads directly when no writes are pending.
module gamma_lut_ctrl #(
  parameter int BITS       = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          pclk,
  input  logic                          rst_n,
  input  logic                          in_vsync,
  input  logic                          in_href,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [1:0]                    host_sel,
  input  logic [BITS-1:0]               host_addr,
  input  logic [BITS-1:0]               host_wdata,
  output logic                          host_ready,
  output logic                          host_rvalid,
  output logic [BITS-1:0]               host_rdata,
  output logic                          lut_r_wen,
  output logic                          lut_g_wen,
  output logic                          lut_b_wen,
  output logic                          lut_r_ren,
  output logic                          lut_g_ren,
  output logic                          lut_b_ren,
  output logic [BITS-1:0]               lut_addr,
  output logic [BITS-1:0]               lut_wdata,
  input  logic [BITS-1:0]               lut_r_rdata,
  input  logic [BITS-1:0]               lut_g_rdata,
  input  logic [BITS-1:0]               lut_b_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   pending,
  output logic                          commit_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WRITE  = 2'd1;
  localparam logic [1:0] READ   = 2'd2;
  localparam logic [1:0] RDWAIT = 2'd3;

  logic [1:0]      state, state_nxt;
  logic [1:0]      fifo_sel  [FIFO_DEPTH];
  logic [BITS-1:0] fifo_addr [FIFO_DEPTH];
  logic [BITS-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_nxt;
  logic            wr_ok, rd_ok;
  logic [1:0]      rd_sel;
  logic            blank, fifo_empty, push, pop, rd_accept;
  logic [1:0]      head_sel;

  assign blank      = !in_vsync && !in_href;
  assign fifo_empty = (count == '0);
  assign head_sel   = fifo_sel[rd_ptr];

  // Both readiness flags are registered; the request direction only picks which one the host sees.
  assign host_ready = host_we ? wr_ok : rd_ok;
  assign push       = host_req && host_we && wr_ok;
  assign rd_accept  = host_req && !host_we && rd_ok;
  assign pop        = !fifo_empty && blank && (state == IDLE || state == WRITE);
  assign count_nxt  = count + CW'(push) - CW'(pop);
  assign pending    = count;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pop)            state_nxt = WRITE;
        else if (rd_accept) state_nxt = READ;
      end
      WRITE:   state_nxt = pop ? WRITE : IDLE;
      READ:    state_nxt = RDWAIT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (push) begin
      fifo_sel[wr_ptr]  <= host_sel;
      fifo_addr[wr_ptr] <= host_addr;
      fifo_data[wr_ptr] <= host_wdata;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_ok  <= 1'b0;
      rd_ok  <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      wr_ok <= (count_nxt != CW'(FIFO_DEPTH));
      rd_ok <= (count_nxt == '0) && (state_nxt == IDLE);
    end
  end

  // A pop always launches a write; an accepted read can only start from an empty, idle queue.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      lut_r_wen   <= 1'b0;
      lut_g_wen   <= 1'b0;
      lut_b_wen   <= 1'b0;
      lut_r_ren   <= 1'b0;
      lut_g_ren   <= 1'b0;
      lut_b_ren   <= 1'b0;
      lut_addr    <= '0;
      lut_wdata   <= '0;
      host_rdata  <= '0;
      host_rvalid <= 1'b0;
      commit_done <= 1'b0;
      rd_sel      <= 2'd0;
    end else begin
      lut_r_wen   <= 1'b0;
      lut_g_wen   <= 1'b0;
      lut_b_wen   <= 1'b0;
      lut_r_ren   <= 1'b0;
      lut_g_ren   <= 1'b0;
      lut_b_ren   <= 1'b0;
      host_rvalid <= 1'b0;
      commit_done <= 1'b0;
      if (pop) begin
        lut_addr  <= fifo_addr[rd_ptr];
        lut_wdata <= fifo_data[rd_ptr];
        lut_r_wen <= (head_sel == 2'd0) || (head_sel == 2'd3);
        lut_g_wen <= (head_sel == 2'd1) || (head_sel == 2'd3);
        lut_b_wen <= (head_sel == 2'd2) || (head_sel == 2'd3);
      end else if (state == IDLE && rd_accept) begin
        lut_addr  <= host_addr;
        rd_sel    <= host_sel;
        lut_r_ren <= (host_sel == 2'd0) || (host_sel == 2'd3);
        lut_g_ren <= (host_sel == 2'd1);
        lut_b_ren <= (host_sel == 2'd2);
      end
      if (state == WRITE && !pop && count_nxt == '0) commit_done <= 1'b1;
      if (state == READ) begin
        host_rvalid <= 1'b1;
        case (rd_sel)
          2'd1:    host_rdata <= lut_g_rdata;
          2'd2:    host_rdata <= lut_b_rdata;
          default: host_rdata <= lut_r_rdata;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Scoreboard bench for gamma_lut_ctrl: directed host traffic pushes expected LUT
// writes, reads and commit pulses; a negedge monitor pops and compares them.
module tb_gamma_lut_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_vsync = 1'b1, in_href = 1'b0;
  logic       host_req = 1'b0, host_we = 1'b1;
  logic [1:0] host_sel = 2'd0;
  logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
  logic       host_ready, host_rvalid;
  logic [7:0] host_rdata;
  logic       lut_r_wen, lut_g_wen, lut_b_wen, lut_r_ren, lut_g_ren, lut_b_ren;
  logic [7:0] lut_addr, lut_wdata, lut_r_rdata, lut_g_rdata, lut_b_rdata;
  logic [2:0] pending;
  logic       commit_done;

  always #5 pclk = ~pclk;

  gamma_lut_ctrl #(.BITS(8), .FIFO_DEPTH(4)) dut (
    .pclk(pclk), .rst_n(rst_n), .in_vsync(in_vsync), .in_href(in_href),
    .host_req(host_req), .host_we(host_we), .host_sel(host_sel),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .lut_r_wen(lut_r_wen), .lut_g_wen(lut_g_wen), .lut_b_wen(lut_b_wen),
    .lut_r_ren(lut_r_ren), .lut_g_ren(lut_g_ren), .lut_b_ren(lut_b_ren),
    .lut_addr(lut_addr), .lut_wdata(lut_wdata),
    .lut_r_rdata(lut_r_rdata), .lut_g_rdata(lut_g_rdata), .lut_b_rdata(lut_b_rdata),
    .pending(pending), .commit_done(commit_done)
  );

  // LUT model: synchronous write, read data presented for the addressed entry.
  logic [7:0] r_mem [256];
  logic [7:0] g_mem [256];
  logic [7:0] b_mem [256];
  always @(posedge pclk) begin
    if (!rst_n) b_mem[8'h05] <= 8'h5A;
    if (lut_r_wen) r_mem[lut_addr] <= lut_wdata;
    if (lut_g_wen) g_mem[lut_addr] <= lut_wdata;
    if (lut_b_wen) b_mem[lut_addr] <= lut_wdata;
  end
  assign lut_r_rdata = r_mem[lut_addr];
  assign lut_g_rdata = g_mem[lut_addr];
  assign lut_b_rdata = b_mem[lut_addr];

  typedef struct packed {logic [2:0] mask; logic [7:0] addr; logic [7:0] data;} wr_t;
  typedef struct packed {logic [2:0] mask; logic [7:0] addr; logic [7:0] data; logic [31:0] due;} rd_t;
  wr_t wq[$];
  rd_t rq[$];
  int  exp_commits = 0;
  int  checks = 0, failures = 0;
  int  cyc = 0;
  int  last_wen_cyc = -10;
  logic blank_at_edge = 1'b0;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    blank_at_edge <= !in_vsync && !in_href;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every DUT-presented event is matched against the scoreboard queues.
  always @(negedge pclk) begin
    logic [2:0] wm, rm;
    wr_t we_exp;
    rd_t re_exp;
    wm = {lut_b_wen, lut_g_wen, lut_r_wen};
    rm = {lut_b_ren, lut_g_ren, lut_r_ren};
    if (wm != 3'b0 || rm != 3'b0) check_output("wen_ren_exclusive", {31'd0, (wm != 3'b0 && rm != 3'b0)}, 32'd0);
    if (wm != 3'b0) begin
      check_output("wen_in_blank", {31'd0, blank_at_edge}, 32'd1);
      if (wq.size() == 0) check_output("wen_unexpected", {21'd0, wm, lut_addr}, 32'd0);
      else begin
        we_exp = wq.pop_front();
        check_output("lut_write", {13'd0, wm, lut_addr, lut_wdata}, {13'd0, we_exp});
      end
      last_wen_cyc = cyc;
    end
    if (rm != 3'b0) begin
      if (rq.size() == 0) check_output("ren_unexpected", {21'd0, rm, lut_addr}, 32'd0);
      else check_output("lut_read", {21'd0, rm, lut_addr}, {21'd0, rq[0].mask, rq[0].addr});
    end
    if (host_rvalid) begin
      if (rq.size() == 0) check_output("rvalid_unexpected", {24'd0, host_rdata}, 32'd0);
      else begin
        re_exp = rq.pop_front();
        check_output("host_rdata", {24'd0, host_rdata}, {24'd0, re_exp.data});
        check_output("read_latency", cyc, re_exp.due);
      end
    end
    if (commit_done) begin
      checks++;
      if (exp_commits > 0 && last_wen_cyc == cyc - 1) exp_commits--;
      else begin
        failures++;
        $display("[TB] FAIL commit_done actual=pulse expected=none (last_wen=%0d cyc=%0d)", last_wen_cyc, cyc);
      end
    end
  end

  task automatic host_write(input logic [1:0] sel, input logic [7:0] addr, input logic [7:0] data,
                            input logic [2:0] mask, input bit track);
    int n = 0;
    host_req = 1'b1; host_we = 1'b1; host_sel = sel; host_addr = addr; host_wdata = data;
    #1;
    while (!host_ready && n < 100) begin @(negedge pclk); n++; end
    if (!host_ready) check_output("write_accept_timeout", 32'd0, 32'd1);
    else if (track) wq.push_back({mask, addr, data});
    @(negedge pclk);
    host_req = 1'b0;
  endtask

  task automatic host_read(input logic [1:0] sel, input logic [7:0] addr, input logic [2:0] mask,
                           input logic [7:0] exp);
    int n = 0;
    host_req = 1'b1; host_we = 1'b0; host_sel = sel; host_addr = addr;
    #1;
    while (!host_ready && n < 100) begin @(negedge pclk); n++; end
    if (!host_ready) check_output("read_accept_timeout", 32'd0, 32'd1);
    else rq.push_back({mask, addr, exp, 32'(cyc + 2)});
    @(negedge pclk);
    host_req = 1'b0; host_we = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (pending != 3'd0 && n < 50) begin @(negedge pclk); n++; end
    check_output("drain_pending", {29'd0, pending}, 32'd0);
  endtask

  task automatic apply_stimulus();
    // Reset values
    @(negedge pclk);
    check_output("rst_pending", {29'd0, pending}, 32'd0);
    check_output("rst_strobes", {24'd0, lut_r_wen, lut_g_wen, lut_b_wen, lut_r_ren, lut_g_ren, lut_b_ren, host_rvalid, commit_done}, 32'd0);
    check_output("rst_data", {8'd0, lut_addr, lut_wdata, host_rdata}, 32'd0);
    rst_n = 1'b1;
    @(negedge pclk);
    check_output("ready_after_rst_wr", {31'd0, host_ready}, 32'd1);
    host_we = 1'b0; #1;
    check_output("ready_after_rst_rd", {31'd0, host_ready}, 32'd1);
    host_we = 1'b1;
    @(negedge pclk);

    // Single green write during blank
    in_vsync = 1'b0;
    exp_commits++;
    host_write(2'd1, 8'h10, 8'hAB, 3'b010, 1'b1);
    wait_drain();
    wait_cycles(3);
    check_output("commit_single", exp_commits, 32'd0);

    // Four writes held during active frame, then drained back-to-back
    in_vsync = 1'b1;
    host_write(2'd0, 8'h01, 8'h11, 3'b001, 1'b1);
    host_write(2'd1, 8'h02, 8'h22, 3'b010, 1'b1);
    host_write(2'd2, 8'h03, 8'h33, 3'b100, 1'b1);
    host_write(2'd0, 8'h04, 8'h44, 3'b001, 1'b1);
    check_output("full_pending", {29'd0, pending}, 32'd4);
    check_output("full_ready", {31'd0, host_ready}, 32'd0);
    wait_cycles(4);
    check_output("held_pending", {29'd0, pending}, 32'd4);
    exp_commits++;
    in_vsync = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      @(negedge pclk);
      check_output("drain_step", {29'd0, pending}, 32'(k));
    end
    wait_cycles(2);
    check_output("commit_burst", exp_commits, 32'd0);

    // Broadcast write
    exp_commits++;
    host_write(2'd3, 8'hFF, 8'h01, 3'b111, 1'b1);
    wait_drain();
    wait_cycles(2);

    // Reads from each channel, broadcast select reads red
    host_read(2'd2, 8'h05, 3'b100, 8'h5A);
    wait_cycles(4);
    host_read(2'd3, 8'hFF, 3'b001, 8'h01);
    wait_cycles(4);
    host_read(2'd1, 8'h10, 3'b010, 8'hAB);
    wait_cycles(4);

    // Read stalled behind a pending write, then returns the newly written value
    in_vsync = 1'b1;
    host_write(2'd1, 8'h20, 8'h77, 3'b010, 1'b1);
    host_req = 1'b1; host_we = 1'b0; host_sel = 2'd1; host_addr = 8'h20; #1;
    check_output("read_stall_ready", {31'd0, host_ready}, 32'd0);
    wait_cycles(3);
    check_output("read_stall_ready2", {31'd0, host_ready}, 32'd0);
    check_output("read_stall_pending", {29'd0, pending}, 32'd1);
    exp_commits++;
    in_vsync = 1'b0;
    host_read(2'd1, 8'h20, 3'b010, 8'h77);
    wait_cycles(4);
    check_output("commit_before_read", exp_commits, 32'd0);

    // Blank drops while the second of three writes is issuing
    in_vsync = 1'b1;
    host_write(2'd0, 8'h30, 8'hA1, 3'b001, 1'b1);
    host_write(2'd1, 8'h31, 8'hB2, 3'b010, 1'b1);
    host_write(2'd2, 8'h32, 8'hC3, 3'b100, 1'b1);
    exp_commits++;
    in_vsync = 1'b0;
    @(negedge pclk);
    check_output("split_first", {29'd0, pending}, 32'd2);
    @(negedge pclk);
    check_output("split_second", {29'd0, pending}, 32'd1);
    in_vsync = 1'b1;
    wait_cycles(4);
    check_output("split_held", {29'd0, pending}, 32'd1);
    check_output("split_no_commit", exp_commits, 32'd1);
    check_output("split_wq_left", wq.size(), 32'd1);
    in_vsync = 1'b0;
    wait_drain();
    wait_cycles(2);
    check_output("split_commit", exp_commits, 32'd0);

    // Reset discards queued writes
    in_vsync = 1'b1;
    host_write(2'd0, 8'h40, 8'hD1, 3'b001, 1'b0);
    host_write(2'd1, 8'h41, 8'hD2, 3'b010, 1'b0);
    host_write(2'd2, 8'h42, 8'hD3, 3'b100, 1'b0);
    check_output("pre_rst_pending", {29'd0, pending}, 32'd3);
    rst_n = 1'b0; #1;
    check_output("mid_rst_pending", {29'd0, pending}, 32'd0);
    @(negedge pclk);
    rst_n = 1'b1;
    @(negedge pclk);
    check_output("post_rst_ready", {31'd0, host_ready}, 32'd1);
    in_vsync = 1'b0;
    wait_cycles(6);
    check_output("post_rst_pending", {29'd0, pending}, 32'd0);

    // Reset discards an in-flight read
    host_read(2'd0, 8'h30, 3'b001, 8'hA1);
    #2;
    rst_n = 1'b0;
    rq.delete();
    @(negedge pclk);
    rst_n = 1'b1;
    wait_cycles(5);
    check_output("final_wq", wq.size(), 32'd0);
    check_output("final_rq", rq.size(), 32'd0);
    check_output("final_commits", exp_commits, 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/gamma_lut_ctrl.md
GAMMA_LUT_CTRL -- requirements
Module: gamma_lut_ctrl

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning LUT address/data width; each LUT holds 2**BITS entries.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning pending-write queue depth (power of 2, >=2).
REQ-003 pclk  in  1  clock; all logic and LUT config ports run on pclk.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 in_vsync  in  1  frame-active flag (high = active frame); monitored only.
REQ-006 in_href  in  1  line-active flag; monitored only.
REQ-007 host_req  in  1  host access request.
REQ-008 host_we  in  1  1 = write, 0 = read.
REQ-009 host_sel  in  2  0 = R, 1 = G, 2 = B, 3 = broadcast.
REQ-010 host_addr  in  BITS  LUT index.
REQ-011 host_wdata  in  BITS  write data.
REQ-012 host_ready  out  1  accept strobe; transfer occurs on a cycle with host_req && host_ready.
REQ-013 host_rvalid  out  1  one-cycle pulse; host_rdata valid.
REQ-014 host_rdata  out  BITS  read result.
REQ-015 lut_r_wen, lut_g_wen, lut_b_wen  out  1 each  per-channel LUT write enable.
REQ-016 lut_r_ren, lut_g_ren, lut_b_ren  out  1 each  per-channel LUT read enable.
REQ-017 lut_addr  out  BITS  shared LUT address.
REQ-018 lut_wdata  out  BITS  shared LUT write data.
REQ-019 lut_r_rdata, lut_g_rdata, lut_b_rdata  in  BITS each  LUT read data, valid 1 cycle after ren.
REQ-020 pending  out  log2(FIFO_DEPTH)+1  queued write count.
REQ-021 commit_done  out  1  one-cycle pulse when the queue drains to empty.

Function
REQ-022 Writes SHALL be accepted into the FIFO {sel, addr, wdata}; for writes, host_ready = FIFO not full.
REQ-023 Reads SHALL be accepted only when FIFO is empty and FSM is IDLE; for reads, host_ready = (pending==0 && state==IDLE).
REQ-024 blank = !in_vsync && !in_href; LUT writes SHALL be issued only on cycles where blank is high.
REQ-025 FSM states SHALL be IDLE, WRITE, READ, RDWAIT.
REQ-026 IDLE->WRITE when FIFO non-empty and blank: pop head, drive lut_addr/lut_wdata, assert wen(s) for exactly one cycle (all three for sel=3).
REQ-027 WRITE->WRITE when FIFO is still non-empty and blank, giving one write per cycle; otherwise WRITE->IDLE.
REQ-028 A write queued while blank is low SHALL be held until blank rises; a write in flight SHALL complete even if blank falls in that cycle.
REQ-029 On accepted read: IDLE->READ asserts ren of the selected channel (sel=3 reads R) with lut_addr for one cycle.
REQ-030 READ->RDWAIT: capture the selected rdata into host_rdata and pulse host_rvalid; RDWAIT->IDLE next cycle; read latency is 2 cycles from acceptance to host_rvalid.
REQ-031 Reads SHALL ignore blank.
REQ-032 Simultaneous host push and FIFO pop SHALL leave pending unchanged; a push when full is impossible by ready.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; ordering is strict FIFO.
REQ-034 commit_done SHALL pulse the cycle after the last queued write's wen when pending becomes 0.
REQ-035 All lut_* and host_* outputs SHALL be registered; wen and ren are never both high.

Reset
REQ-036 On rst_n low: FSM to IDLE; FIFO flushed (pending = 0); all wen, ren, host_rvalid and commit_done = 0; lut_addr, lut_wdata and host_rdata = 0; host_ready = 1 one cycle after deassertion.
REQ-037 Reset mid-operation SHALL discard queued writes and any in-flight read without emitting host_rvalid.

Verification
REQ-038 vsync=0, href=0; write sel=1, addr=0x10, data=0xAB -> lut_g_wen=1 for one cycle with lut_addr=0x10, lut_wdata=0xAB; commit_done pulses the next cycle.
REQ-039 vsync=1; queue 4 writes -> host_ready=0, pending=4, no wen; drop vsync -> 4 consecutive single-cycle wen pulses in queue order, then pending=0.
REQ-040 Broadcast write sel=3, addr=0xFF, data=0x01 during blank -> lut_r_wen, lut_g_wen and lut_b_wen all high in the same cycle.
REQ-041 Read sel=2, addr=0x05 with lut_b_rdata model returning 0x5A -> lut_b_ren for one cycle; host_rvalid with host_rdata=0x5A 2 cycles after acceptance; a read while pending>0 is stalled with host_ready=0.
REQ-042 Queue 3 writes during active frame, assert rst_n low -> pending=0, no wen after reset, host_ready=1.
REQ-043 Blank falls while the 2nd of 3 queued writes issues -> 2nd write completes, 3rd waits for next blank.
